// File: rtl/impulse_scan_sequencer_if.sv
// Control, status and mux-side signals of the impulse scan sequencer.
// The sequencer drives the mux select, so it takes the master modport.
interface impulse_scan_sequencer_if;
  logic       ena;
  logic       start;
  logic       continuous;
  logic       abort;
  logic       mux_in;
  logic [3:0] select;
  logic       busy;
  logic [8:0] frame;
  logic       frame_valid;

  modport master (
    input  ena, start, continuous, abort, mux_in,
    output select, busy, frame, frame_valid
  );

  modport slave (
    output ena, start, continuous, abort, mux_in,
    input  select, busy, frame, frame_valid
  );
endinterface

// File: rtl/impulse_scan_sequencer.sv
// Steps the 9:1 mux select through channels 1..9, samples each channel after
// DWELL cycles and publishes the assembled 9-bit frame with a one-cycle strobe.
module impulse_scan_sequencer #(
  parameter int unsigned DWELL = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  impulse_scan_sequencer_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [3:0] RELOAD   = 4'(DWELL - 1);
  localparam logic [3:0] LAST_SEL = 4'd9;

  state_t     state_q, state_d;
  logic [3:0] select_q, select_d;
  logic [3:0] dwell_q, dwell_d;
  logic [8:0] shreg_q, shreg_d;
  logic [8:0] frame_q, frame_d;
  logic       frame_valid_q, frame_valid_d;
  logic [3:0] bit_idx;

  assign bit_idx = select_q - 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      select_q      <= '0;
      dwell_q       <= '0;
      shreg_q       <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      select_q      <= select_d;
      dwell_q       <= dwell_d;
      shreg_q       <= shreg_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    select_d      = select_q;
    dwell_d       = dwell_q;
    shreg_d       = shreg_q;
    frame_d       = frame_q;
    // Strobe clears even while frozen so it is never stretched.
    frame_valid_d = 1'b0;

    if (bus.ena) begin
      if (bus.abort) begin
        state_d  = IDLE;
        select_d = '0;
        dwell_d  = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            select_d = '0;
            if (bus.start) begin
              state_d  = SCAN;
              select_d = 4'd1;
              dwell_d  = RELOAD;
            end
          end
          SCAN: begin
            if (dwell_q != '0) begin
              dwell_d = dwell_q - 4'd1;
            end else begin
              shreg_d[bit_idx] = bus.mux_in;
              if (select_q < LAST_SEL) begin
                select_d = select_q + 4'd1;
                dwell_d  = RELOAD;
              end else begin
                // Frame takes the final sample directly, not the stale register.
                frame_d       = shreg_d;
                frame_valid_d = 1'b1;
                select_d      = '0;
                state_d       = GAP;
              end
            end
          end
          GAP: begin
            if (bus.continuous) begin
              state_d  = SCAN;
              select_d = 4'd1;
              dwell_d  = RELOAD;
            end else begin
              state_d  = IDLE;
              select_d = '0;
            end
          end
          default: begin
            state_d  = IDLE;
            select_d = '0;
            dwell_d  = '0;
          end
        endcase
      end
    end
  end

  assign bus.select      = select_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame       = frame_q;
  assign bus.frame_valid = frame_valid_q;

endmodule

// File: tb/tb_impulse_scan_sequencer.sv
// Scoreboarded bench: a timing-arithmetic model predicts select/busy/frame and
// queues expected frames; a negedge monitor compares against the DUT.
module tb_impulse_scan_sequencer;

  localparam int DW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [8:0] mux_data;
  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  impulse_scan_sequencer_if bus ();

  impulse_scan_sequencer #(.DWELL(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Combinational 9:1 mux: select 0 outputs 0, 1..9 map to channel 0..8.
  assign bus.mux_in = (bus.select >= 4'd1 && bus.select <= 4'd9) ?
                      mux_data[bus.select - 4'd1] : 1'b0;

  // Reference model: position within a scan counted in enabled cycles.
  bit         m_active = 1'b0;
  bit         m_gap    = 1'b0;
  int         m_pos    = 0;
  logic [8:0] m_cap    = '0;
  logic [8:0] m_frame  = '0;
  bit         m_fv     = 1'b0;
  logic [8:0] exp_q[$];

  function automatic int exp_sel();
    return m_active ? (m_pos / DW + 1) : 0;
  endfunction

  task automatic model_step();
    m_fv = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0; m_gap = 1'b0; m_pos = 0; m_cap = '0; m_frame = '0;
      exp_q.delete();
    end else if (bus.ena) begin
      if (bus.abort) begin
        m_active = 1'b0; m_gap = 1'b0;
      end else if (m_active) begin
        m_pos++;
        if (m_pos % DW == 0) m_cap[m_pos / DW - 1] = mux_data[m_pos / DW - 1];
        if (m_pos == 9 * DW) begin
          m_frame = m_cap; m_fv = 1'b1; exp_q.push_back(m_cap);
          m_active = 1'b0; m_gap = 1'b1;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
        if (bus.continuous) begin m_active = 1'b1; m_pos = 0; end
      end else if (bus.start) begin
        m_active = 1'b1; m_pos = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("select", 9'(bus.select), 9'(exp_sel()));
      check("busy", 9'(bus.busy), 9'(m_active | m_gap));
      check("frame_valid", 9'(bus.frame_valid), 9'(m_fv));
      check("frame", bus.frame, m_frame);
      if (bus.frame_valid === 1'b1) begin
        if (exp_q.size() == 0) check("sb_unexpected", 9'd1, 9'd0);
        else check("sb_frame", bus.frame, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic bit cond(input int kind, input int arg);
    case (kind)
      0:       return m_gap;
      1:       return m_fv;
      2:       return !m_active && !m_gap;
      3:       return m_active && m_pos == 9 * DW - 1;
      default: return m_active && exp_sel() == arg;
    endcase
  endfunction

  task automatic wait_until(input string name, input int kind, input int arg, input int budget);
    int n = 0;
    while (!cond(kind, arg) && n < budget) begin tick(); n++; end
    if (!cond(kind, arg)) begin
      total++; bad++;
      $display("FAIL wait_%s: condition not reached within %0d cycles", name, budget);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mux_data = '0;
    bus.ena = 1'b1; bus.start = 1'b0; bus.continuous = 1'b0; bus.abort = 1'b0;

    // Reset then idle
    tick(); checking = 1'b1; tick();
    rst_n = 1'b1;
    ticks(20);

    // One-shot with fixed data
    mux_data = 9'h1A5;
    pulse_start();
    ticks(9 * DW + 4);

    // Continuous: data switches during the gap before frame 2
    mux_data = 9'($urandom);
    bus.continuous = 1'b1;
    pulse_start();
    wait_until("gap1", 0, 0, 40);
    mux_data = 9'h0F0;
    tick();
    wait_until("gap2", 0, 0, 40);
    tick();
    ticks(3);
    bus.continuous = 1'b0;
    wait_until("idle_cont", 2, 0, 40);
    ticks(2);

    // Abort on the final sample edge
    mux_data = 9'($urandom);
    pulse_start();
    wait_until("last_edge", 3, 0, 40);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    ticks(4);

    // ena freeze mid-scan and during the strobe cycle
    mux_data = 9'($urandom);
    pulse_start();
    wait_until("sel4", 4, 4, 40);
    bus.ena = 1'b0; ticks(5); bus.ena = 1'b1;
    wait_until("fv", 1, 0, 40);
    bus.ena = 1'b0; ticks(2); bus.ena = 1'b1;
    ticks(4);

    // Start while busy, then reset mid-scan at select 6
    mux_data = 9'($urandom);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      bus.start = 1'($urandom_range(0, 1)); tick();
    end
    bus.start = 1'b0;
    wait_until("sel6", 4, 6, 40);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    ticks(4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.ena        = ($urandom_range(0, 9) != 0);
      bus.start      = ($urandom_range(0, 4) == 0);
      bus.continuous = ($urandom_range(0, 1) == 1);
      bus.abort      = ($urandom_range(0, 39) == 0);
      rst_n          = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 9) == 0) mux_data = 9'($urandom);
      tick();
    end
    rst_n = 1'b1; bus.ena = 1'b1; bus.start = 1'b0;
    bus.continuous = 1'b0; bus.abort = 1'b0;
    ticks(3 * 9 * DW);

    @(negedge clk);
    check("sb_drained", 9'(exp_q.size()), 9'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
